// File: rtl/conv_window_gen_if.sv
// conv_window_gen_if: pixel-in / window-out handshake bundle for conv_window_gen.
interface conv_window_gen_if #(parameter int DATA_W = 8);
    logic [DATA_W-1:0] pix_in;
    logic              pix_valid;
    logic              pix_ready;
    logic [DATA_W-1:0] win0, win1, win2, win3, win4, win5, win6, win7, win8;
    logic              win_valid;
    logic              win_ready;
    logic              win_last;
    modport master (
        output pix_in, pix_valid, win_ready,
        input  pix_ready, win0, win1, win2, win3, win4, win5, win6, win7, win8, win_valid, win_last
    );
    modport slave (
        input  pix_in, pix_valid, win_ready,
        output pix_ready, win0, win1, win2, win3, win4, win5, win6, win7, win8, win_valid, win_last
    );
endinterface

// File: rtl/conv_window_gen.sv
// conv_window_gen: streaming 3x3 sliding-window generator with two line buffers.
// Optional macro CONV_WINGEN_STRIDE2_EN emits windows only at even (row-2, col-2).
module conv_window_gen #(
    parameter int DATA_W = 8,
    parameter int IMG_W  = 28,
    parameter int IMG_H  = 28
) (
    input logic clk,
    input logic rst_n,
    conv_window_gen_if.slave bus
);
    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam logic [CW-1:0] C_MAX = CW'(IMG_W - 1);
    localparam logic [RW-1:0] R_MAX = RW'(IMG_H - 1);
`ifdef CONV_WINGEN_STRIDE2_EN
    localparam logic [CW-1:0] C_LAST = CW'(2 + 2 * ((IMG_W - 3) / 2));
    localparam logic [RW-1:0] R_LAST = RW'(2 + 2 * ((IMG_H - 3) / 2));
`else
    localparam logic [CW-1:0] C_LAST = C_MAX;
    localparam logic [RW-1:0] R_LAST = R_MAX;
`endif
    typedef enum logic [1:0] {IDLE, PRIME, RUN} state_t;
    state_t state, state_nx;
    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic [DATA_W-1:0] lb0 [IMG_W];
    logic [DATA_W-1:0] lb1 [IMG_W];
    logic [DATA_W-1:0] w [9];
    logic win_valid, win_last;
    logic accept, col_end, row_end, pos_ok, emit, emit_en;
    assign bus.pix_ready = !win_valid || bus.win_ready;
    assign accept  = bus.pix_valid && bus.pix_ready;
    assign col_end = col == C_MAX;
    assign row_end = row == R_MAX;
`ifdef CONV_WINGEN_STRIDE2_EN
    assign pos_ok = row >= RW'(2) && col >= CW'(2) && !row[0] && !col[0];
`else
    assign pos_ok = row >= RW'(2) && col >= CW'(2);
`endif
    assign emit = accept && emit_en && pos_ok;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end
    always_comb begin
        state_nx = state;
        if (accept)
            state_nx = state == IDLE ? PRIME :
                       (state == PRIME && row == RW'(1) && col_end) ? RUN :
                       (state == RUN && row_end && col_end) ? IDLE : state;
    end
    always_comb begin
        emit_en = state == RUN;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col       <= '0;
            row       <= '0;
            win_valid <= 1'b0;
            win_last  <= 1'b0;
            for (int i = 0; i < 9; i++) w[i] <= '0;
        end else begin
            if (accept) begin
                col <= col_end ? '0 : col + 1'b1;
                if (col_end) row <= row_end ? '0 : row + 1'b1;
                {w[0], w[1], w[2]} <= {w[1], w[2], lb1[col]};
                {w[3], w[4], w[5]} <= {w[4], w[5], lb0[col]};
                {w[6], w[7], w[8]} <= {w[7], w[8], bus.pix_in};
            end
            // An accept implies any pending window is consumed this same edge.
            win_valid <= accept ? emit : (bus.win_ready ? 1'b0 : win_valid);
            win_last  <= accept ? (emit && row == R_LAST && col == C_LAST)
                                : (bus.win_ready ? 1'b0 : win_last);
        end
    end
    always_ff @(posedge clk) begin
        if (accept) begin
            lb1[col] <= lb0[col];
            lb0[col] <= bus.pix_in;
        end
    end
    assign bus.win0      = w[0];
    assign bus.win1      = w[1];
    assign bus.win2      = w[2];
    assign bus.win3      = w[3];
    assign bus.win4      = w[4];
    assign bus.win5      = w[5];
    assign bus.win6      = w[6];
    assign bus.win7      = w[7];
    assign bus.win8      = w[8];
    assign bus.win_valid = win_valid;
    assign bus.win_last  = win_last;
endmodule
